// File: rtl/instr_enc_pkg.sv
// Shared constants and helpers for the RV32I instruction encoder.
package instr_enc_pkg;

  // Opcode encodings, identical to the decode side
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_U   = 7'b0110111;
  localparam logic [6:0] OP_UPC = 7'b0010111;

  // addi x0,x0,0 -- substituted for any rejected request
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

  // Instruction layout family; FMT_SH is the I-type shift variant
  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_SH,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U,
    FMT_BAD
  } fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] op, input logic [2:0] f3);
    fmt_e f;
    case (op)
      OP_R:          f = FMT_R;
      OP_I:          f = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
      OP_LD, OP_JR:  f = FMT_I;
      OP_S:          f = FMT_S;
      OP_B:          f = FMT_B;
      OP_J:          f = FMT_J;
      OP_U, OP_UPC:  f = FMT_U;
      default:       f = FMT_BAD;
    endcase
    return f;
  endfunction

  // Signed compare over all 32 bits, so upper bits must match the sign extension
  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_enc_imm_pack.sv
// Immediate range/alignment check and scatter into format bit positions.
// Only immediate-bearing bits are driven; the caller ORs in the other fields.
module instr_enc_imm_pack
  import instr_enc_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_imm,
  output fmt_e        o_fmt,
  output logic [31:0] o_imm_bits,
  output logic        o_err
);

  fmt_e w_fmt;

  assign w_fmt = fmt_of(i_opcode, i_funct3);
  assign o_fmt = w_fmt;

  // Per-format range check and bit scatter
  always_comb begin
    o_imm_bits = '0;
    o_err      = 1'b0;
    case (w_fmt)
      FMT_R: begin
        o_imm_bits = '0;
      end
      FMT_I: begin
        o_err      = !imm_in_range(i_imm, -2048, 2047);
        o_imm_bits = {i_imm[11:0], 20'b0};
      end
      FMT_SH: begin
        o_err      = !imm_in_range(i_imm, 0, 31);
        o_imm_bits = {7'b0, i_imm[4:0], 20'b0};
      end
      FMT_S: begin
        o_err      = !imm_in_range(i_imm, -2048, 2047);
        o_imm_bits = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
      end
      FMT_B: begin
        o_err      = !imm_in_range(i_imm, -4096, 4094) || i_imm[0];
        o_imm_bits = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
      end
      FMT_J: begin
        o_err      = !imm_in_range(i_imm, -1048576, 1048574) || i_imm[0];
        o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
      end
      FMT_U: begin
        o_err      = |i_imm[11:0];
        o_imm_bits = {i_imm[31:12], 12'b0};
      end
      default: begin
        o_err      = 1'b1;
        o_imm_bits = '0;
      end
    endcase
  end

endmodule

// File: rtl/instr_enc.sv
// Two-stage RV32I instruction encoder with valid/ready on both sides.
// Stage 1 captures the request and its check result; stage 2 builds the word.
module instr_enc
  import instr_enc_pkg::*;
#(
  parameter int          CNT_W    = 8,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [6:0]       i_opcode,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [2:0]       i_funct3,
  input  logic [6:0]       i_funct7,
  input  logic [31:0]      i_imm,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_instr,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt
);

  // stage 1 registers
  logic             r_s1_valid;
  logic [6:0]       r_s1_op;
  logic [4:0]       r_s1_rd;
  logic [4:0]       r_s1_rs1;
  logic [4:0]       r_s1_rs2;
  logic [2:0]       r_s1_f3;
  logic [6:0]       r_s1_f7;
  fmt_e             r_s1_fmt;
  logic [31:0]      r_s1_imm_bits;
  logic             r_s1_err;

  // stage 2 / output registers
  logic             r_s2_valid;
  logic [31:0]      r_instr;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_accept;
  fmt_e             w_fmt;
  logic [31:0]      w_imm_bits;
  logic             w_err;
  logic [31:0]      w_word;

  instr_enc_imm_pack u_imm_pack (
    .i_opcode   (i_opcode),
    .i_funct3   (i_funct3),
    .i_imm      (i_imm),
    .o_fmt      (w_fmt),
    .o_imm_bits (w_imm_bits),
    .o_err      (w_err)
  );

  assign w_adv2   = !r_s2_valid || i_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign w_accept = i_valid && w_adv1;
  assign o_ready  = w_adv1;

  // Merge register, funct and opcode fields into the scattered immediate
  always_comb begin
    w_word = r_s1_imm_bits | {25'b0, r_s1_op};
    case (r_s1_fmt)
      FMT_R:   w_word = w_word | {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, 7'b0};
      FMT_I:   w_word = w_word | {12'b0, r_s1_rs1, r_s1_f3, r_s1_rd, 7'b0};
      FMT_SH:  w_word = w_word | {r_s1_f7, 5'b0, r_s1_rs1, r_s1_f3, r_s1_rd, 7'b0};
      FMT_S,
      FMT_B:   w_word = w_word | {7'b0, r_s1_rs2, r_s1_rs1, r_s1_f3, 12'b0};
      FMT_J,
      FMT_U:   w_word = w_word | {20'b0, r_s1_rd, 7'b0};
      default: w_word = w_word;
    endcase
  end

  // Stage 1: capture request fields and check result on accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= i_valid;
      if (w_accept) begin
        r_s1_op       <= i_opcode;
        r_s1_rd       <= i_rd;
        r_s1_rs1      <= i_rs1;
        r_s1_rs2      <= i_rs2;
        r_s1_f3       <= i_funct3;
        r_s1_f7       <= i_funct7;
        r_s1_fmt      <= w_fmt;
        r_s1_imm_bits <= w_imm_bits;
        r_s1_err      <= w_err;
      end
    end
  end

  // Stage 2: register the word (or NOP on reject) and count rejects, saturating
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_instr    <= '0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_instr <= r_s1_err ? NOP_WORD : w_word;
        r_err   <= r_s1_err;
        if (r_s1_err && (r_err_cnt != {CNT_W{1'b1}})) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

  assign o_valid   = r_s2_valid;
  assign o_instr   = r_instr;
  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_instr_enc.sv
// Directed table-driven bench for instr_enc plus multi-cycle corner sequences.
module tb_instr_enc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [6:0]  i_opcode;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [31:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic        o_err;
  logic [7:0]  o_err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t tbl[22];

  instr_enc #(.CNT_W(8), .NOP_WORD(32'h0000_0013)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_opcode  (i_opcode),
    .i_rd      (i_rd),
    .i_rs1     (i_rs1),
    .i_rs2     (i_rs2),
    .i_funct3  (i_funct3),
    .i_funct7  (i_funct7),
    .i_imm     (i_imm),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_instr   (o_instr),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Independent inverse: pull the immediate back out of an encoded word
  function automatic logic [31:0] dec_imm(input logic [31:0] w);
    logic [31:0] r;
    case (w[6:0])
      7'h13:   r = (w[14:12] == 3'b001 || w[14:12] == 3'b101) ? {27'b0, w[24:20]}
                                                              : {{20{w[31]}}, w[31:20]};
      7'h03,
      7'h67:   r = {{20{w[31]}}, w[31:20]};
      7'h23:   r = {{20{w[31]}}, w[31:25], w[11:7]};
      7'h63:   r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'h6F:   r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      7'h37,
      7'h17:   r = {w[31:12], 12'b0};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic apply(input vec_t v);
    i_opcode = v.op;
    i_rd     = v.rd;
    i_rs1    = v.rs1;
    i_rs2    = v.rs2;
    i_funct3 = v.f3;
    i_funct7 = v.f7;
    i_imm    = v.imm;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One isolated request: latency, word, error flag, counter, round trip, no duplicate
  task automatic send_one(input vec_t v, input int exp_cnt, input string nm);
    int lat;
    apply(v);
    i_valid = 1'b1;
    i_ready = 1'b1;
    #1;
    chk({nm, "_ready"}, 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    chk({nm, "_instr"}, o_instr, v.exp);
    chk({nm, "_err"}, 32'(o_err), 32'(v.exp_err));
    chk({nm, "_cnt"}, 32'(o_err_cnt), 32'(exp_cnt));
    if (!v.exp_err && v.op != 7'h33)
      chk({nm, "_roundtrip"}, dec_imm(o_instr), v.imm);
    @(posedge clk); #1;
    chk({nm, "_drained"}, 32'(o_valid), 32'd0);
  endtask

  initial begin : main
    int ecnt;
    int sent;
    int rcvd;
    logic take_in;
    logic take_out;
    logic [31:0] held;
    vec_t bad;
    vec_t rej[3];

    //         op     rd  rs1 rs2 f3    f7     imm           exp           err
    tbl[0]  = '{7'h13, 1,  0,  0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
    tbl[1]  = '{7'h23, 0,  1,  2, 3'd2, 7'h00, 32'h00000008, 32'h0020A423, 1'b0};
    tbl[2]  = '{7'h63, 0,  0,  0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
    tbl[3]  = '{7'h6F, 1,  0,  0, 3'd0, 7'h00, 32'h00000800, 32'h001000EF, 1'b0};
    tbl[4]  = '{7'h37, 5,  0,  0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0};
    tbl[5]  = '{7'h33, 3,  1,  2, 3'd0, 7'h20, 32'h0000007B, 32'h402081B3, 1'b0};
    tbl[6]  = '{7'h13, 5,  6,  0, 3'd1, 7'h00, 32'h0000001F, 32'h01F31293, 1'b0};
    tbl[7]  = '{7'h13, 5,  6,  0, 3'd5, 7'h20, 32'h00000003, 32'h40335293, 1'b0};
    tbl[8]  = '{7'h13, 5,  6,  0, 3'd1, 7'h00, 32'h00000020, 32'h00000013, 1'b1};
    tbl[9]  = '{7'h03, 10, 2,  0, 3'd2, 7'h00, 32'h000007FF, 32'h7FF12503, 1'b0};
    tbl[10] = '{7'h13, 1,  0,  0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0};
    tbl[11] = '{7'h67, 1,  5,  0, 3'd0, 7'h00, 32'hFFFFF800, 32'h800280E7, 1'b0};
    tbl[12] = '{7'h17, 2,  0,  0, 3'd0, 7'h00, 32'hFFFFF000, 32'hFFFFF117, 1'b0};
    tbl[13] = '{7'h37, 5,  0,  0, 3'd0, 7'h00, 32'h12345001, 32'h00000013, 1'b1};
    tbl[14] = '{7'h6F, 0,  0,  0, 3'd0, 7'h00, 32'hFFF00000, 32'h8000006F, 1'b0};
    tbl[15] = '{7'h6F, 0,  0,  0, 3'd0, 7'h00, 32'h000FFFFE, 32'h7FFFF06F, 1'b0};
    tbl[16] = '{7'h6F, 0,  0,  0, 3'd0, 7'h00, 32'h00100000, 32'h00000013, 1'b1};
    tbl[17] = '{7'h63, 0,  0,  0, 3'd0, 7'h00, 32'h00000FFE, 32'h7E000FE3, 1'b0};
    tbl[18] = '{7'h63, 0,  0,  0, 3'd0, 7'h00, 32'hFFFFF000, 32'h80000063, 1'b0};
    tbl[19] = '{7'h63, 0,  0,  0, 3'd0, 7'h00, 32'hFFFFEFFE, 32'h00000013, 1'b1};
    tbl[20] = '{7'h23, 0,  1,  2, 3'd2, 7'h00, 32'hFFFFF7FF, 32'h00000013, 1'b1};
    tbl[21] = '{7'h13, 1,  1,  0, 3'd1, 7'h00, 32'hFFFFFFFF, 32'h00000013, 1'b1};

    rej[0] = '{7'h13, 1, 0, 0, 3'd0, 7'h00, 32'h00000800, 32'h00000013, 1'b1};
    rej[1] = '{7'h63, 0, 0, 0, 3'd0, 7'h00, 32'h00000003, 32'h00000013, 1'b1};
    rej[2] = '{7'h7F, 0, 0, 0, 3'd0, 7'h00, 32'h00000000, 32'h00000013, 1'b1};
    bad    = rej[2];

    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    apply(tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_cnt", 32'(o_err_cnt), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);

    ecnt = 0;
    for (int i = 0; i < 22; i++) begin
      if (tbl[i].exp_err) ecnt++;
      send_one(tbl[i], ecnt, $sformatf("vec%0d", i));
    end

    // Three rejections in a row
    do_reset();
    for (int i = 0; i < 3; i++)
      send_one(rej[i], i + 1, $sformatf("rej%0d", i));
    chk("rej_total", 32'(o_err_cnt), 32'd3);

    // Backpressure: five back-to-back requests, downstream stalled four cycles
    do_reset();
    sent = 0;
    rcvd = 0;
    held = 32'h0;
    for (int cyc = 0; cyc < 40 && rcvd < 5; cyc++) begin
      i_ready = (cyc >= 4);
      i_valid = (sent < 5);
      if (sent < 5) apply(tbl[sent]);
      #1;
      if (cyc == 2) begin
        chk("bp_accepts", 32'(sent), 32'd2);
        chk("bp_ready_low", 32'(o_ready), 32'd0);
        held = o_instr;
      end
      if (cyc == 3) begin
        chk("bp_ready_low2", 32'(o_ready), 32'd0);
        chk("bp_valid_held", 32'(o_valid), 32'd1);
        chk("bp_instr_stable", o_instr, held);
      end
      take_in  = i_valid && o_ready;
      take_out = o_valid && i_ready;
      if (take_out) begin
        chk($sformatf("bp_out%0d", rcvd), o_instr, tbl[rcvd].exp);
        chk($sformatf("bp_rt%0d", rcvd), dec_imm(o_instr), tbl[rcvd].imm);
        rcvd++;
      end
      @(posedge clk); #1;
      if (take_in) sent++;
    end
    i_valid = 1'b0;
    chk("bp_delivered", 32'(rcvd), 32'd5);
    @(posedge clk); #1;
    chk("bp_no_dup", 32'(o_valid), 32'd0);

    // Saturating counter: 260 rejected requests streamed at full rate
    do_reset();
    apply(bad);
    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 260; k++) begin
      @(posedge clk); #1;
      if (k == 99) chk("sat_mid", 32'(o_err_cnt), 32'd99);
    end
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_cnt", 32'(o_err_cnt), 32'd255);

    // Reset with both stages full; reset must win over a valid request
    do_reset();
    i_ready = 1'b0;
    apply(bad);
    i_valid = 1'b1;
    @(posedge clk); #1;
    apply(tbl[1]);
    @(posedge clk); #1;
    chk("mid_full_ready", 32'(o_ready), 32'd0);
    chk("mid_full_valid", 32'(o_valid), 32'd1);
    chk("mid_full_cnt", 32'(o_err_cnt), 32'd1);
    rst_n = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_valid = 1'b0;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_cnt", 32'(o_err_cnt), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    chk("mid_rst_flushed", 32'(o_valid), 32'd0);
    send_one(tbl[0], 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_enc.md
Name: instr_enc

Overview:
- Pipelined RV32I instruction encoder, the inverse of the decode-side immediate extraction.
- Accepts opcode, register fields, funct fields and a full 32-bit signed immediate. Range- and alignment-checks the immediate, scatters it into the format-specific bit positions, and emits the 32-bit instruction word.
- Used by the self-test/boot sequencer and the testbench stimulus path to build instruction streams into instruction memory.
- Valid/ready on both sides; 2-stage pipeline; throughput one instruction per cycle.

Parameters:
- CNT_W, 8, width of the saturating error counter o_err_cnt.
- NOP_WORD, 32'h0000_0013, word emitted in place of any rejected instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  upstream request valid.
- o_ready  out  1  encoder can accept this cycle.
- i_opcode  in  7  opcode, same encodings as the decode side.
- i_rd  in  5  destination register.
- i_rs1  in  5  source register 1.
- i_rs2  in  5  source register 2.
- i_funct3  in  3  funct3.
- i_funct7  in  7  funct7 (R-type; I-type shifts).
- i_imm  in  32  signed byte-offset immediate; U/UPC carry the full upper value with the low 12 bits zero.
- o_valid  out  1  encoded word valid.
- i_ready  in  1  downstream accepts.
- o_instr  out  32  encoded instruction.
- o_err  out  1  qualifies o_valid; high means the word is NOP_WORD due to a rejected request.
- o_err_cnt  out  CNT_W  saturating count of rejected requests.

Behaviour:
- Reset (rst_n==0 at clk edge): s1_valid=0, s2_valid=0, o_valid=0, o_instr=0, o_err=0, o_err_cnt=0. Any in-flight request is dropped. Reset wins over every handshake in the same cycle.
- Handshake:
  - advance2 = !s2_valid | i_ready.
  - advance1 = !s1_valid | advance2.
  - o_ready = advance1, combinational from state and i_ready, never from i_valid.
  - Accept = i_valid & o_ready.
  - o_valid/o_instr/o_err are held stable while o_valid & !i_ready.
- Stage 1 (on accept): register all fields. Compute err1 = format check fails, and store it with the fields.
- Stage 2 (on advance2 with s1_valid): register o_instr = err1 ? NOP_WORD : packed word; o_err = err1. If neither stage is valid, the output is simply not valid; it never carries a false valid.
- Latency: accept edge to o_valid = 2 clk with no backpressure. Order is preserved, with no loss and no duplication.
- Format by opcode:
  - R 0110011: {f7,rs2,rs1,f3,rd,op}; imm ignored.
  - I 0010011, LD 0000011, JR 1100111: imm in [-2048,2047]; {imm[11:0],rs1,f3,rd,op}.
  - I with f3=001 or 101 (shift): imm in [0,31]; {f7,imm[4:0],rs1,f3,rd,op}.
  - S 0100011: imm in [-2048,2047]; {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - B 1100011: imm in [-4096,4094] and imm[0]==0; {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - J 1101111: imm in [-2^20,2^20-2] and imm[0]==0; {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
  - U 0110111, UPC 0010111: imm[11:0]==0; {imm[31:12],rd,op}.
  - Any other opcode: error.
- Range checks: signed compare on the full 32 bits, i.e. the upper bits must equal the sign extension.
- Error counter: increments by 1 when a word with err1=1 enters stage 2. It saturates at all-ones and does not wrap.
- Simultaneous accept and output drain: both proceed in the same edge. A full pipeline with i_ready=1 sustains 1/cycle.

Decomposition:
- Opcode constants (I, LD, S, B, J, JR, U, UPC, plus new R=0110011) live in the shared parameters.vh. Add R there; do not duplicate the constants locally.
- NOP_WORD is also defined in parameters.vh.
- One natural combinational sub-module: imm_pack (inputs: opcode, f3, f7, imm; outputs: the 32-bit imm-bearing bit mask and err). instr_enc ORs in the register, funct and opcode fields.

Test Plan:
- Addi: op=I, rd=1, rs1=0, f3=000, imm=-1 -> o_instr=0xFFF00093, o_err=0, o_valid exactly 2 cycles after accept.
- Store and branch: sw op=S, rs1=1, rs2=2, f3=010, imm=8 -> 0x0020A423. beq op=B, rs1=0, rs2=0, imm=-4 -> 0xFE000EE3.
- Jump and upper-immediate: jal op=J, rd=1, imm=2048 -> 0x001000EF. lui op=U, rd=5, imm=0x12345000 -> 0x123452B7.
- Rejections: addi imm=2048, then beq imm=3, then op=0x7F -> three words of 0x00000013, each with o_err=1, o_err_cnt=3. Also force CNT_W saturation (255 stays 255).
- Backpressure: 5 back-to-back requests, i_ready=0 for 4 cycles -> o_ready drops after 2 accepts, o_instr stable while stalled, all 5 delivered in order once i_ready=1. Round-trip scoreboard: decoding the emitted immediate reproduces i_imm.
- Reset mid-stream: rst_n=0 for one edge with both stages full -> next cycle o_valid=0, o_err_cnt=0, o_ready=1. A request accepted right after reset encodes correctly.
